// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: bus width, FSM/owner enums
// and the latched request record.
package dmem_arbiter_pkg;

  localparam int XLEN     = 32;
  localparam int LAT_W    = 3;   // holds MEM_LATENCY up to 7
  localparam int STARVE_W = 4;   // holds STARVE_LIMIT up to 15

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} dmem_arb_state_e;
  typedef enum logic {OWN_CORE, OWN_DBG} dmem_owner_e;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } dmem_req_t;

  function automatic dmem_req_t mk_req(input logic we, input logic [XLEN-1:0] addr,
                                       input logic [XLEN-1:0] wdata);
    dmem_req_t r;
    r.we    = we;
    r.addr  = addr;
    r.wdata = wdata;
    return r;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of core, debug/loader and SRAM signals around the arbiter.
// master = requesters + SRAM model side, slave = the arbiter.
interface dmem_arbiter_if;
  import dmem_arbiter_pkg::*;

  logic            core_req;
  logic            core_we;
  logic [XLEN-1:0] core_addr;
  logic [XLEN-1:0] core_wdata;
  logic [XLEN-1:0] core_rdata;
  logic            core_done;
  logic            pipe_stall;

  logic            dbg_req;
  logic            dbg_we;
  logic [XLEN-1:0] dbg_addr;
  logic [XLEN-1:0] dbg_wdata;
  logic [XLEN-1:0] dbg_rdata;
  logic            dbg_done;

  logic            mem_en;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_rdata, core_done, pipe_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_rdata, dbg_done,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_rdata, core_done, pipe_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_rdata, dbg_done,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_lat_timer.sv
// Memory-latency down-counter: load on issue, decrement while waiting,
// flag the cycle in which read data is due.
module dmem_lat_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         last
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)                   cnt <= '0;
    else if (load)             cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - W'(1);
  end

  assign last = (cnt == W'(1));

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data SRAM arbiter between the MEM stage and a debug/loader port.
// Debug port and starvation guard are built only when DMEM_DBG_PORT_EN is defined.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus
);

  dmem_arb_state_e state, state_nxt;
  dmem_owner_e     owner, owner_nxt;
  dmem_req_t       req, req_nxt;

  logic            dbg_pick;
  logic            tmr_load, tmr_dec, tmr_last;
  logic            rsp_cycle;
  logic            mem_en;
  logic            core_done;
  logic [XLEN-1:0] core_rdata;

  dmem_lat_timer #(.W(LAT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (LAT_W'(MEM_LATENCY)),
    .dec      (tmr_dec),
    .last     (tmr_last)
  );

  // Final WAIT cycle: read data is on mem_rdata and RESP follows.
  assign rsp_cycle = (state == WAIT) && tmr_last;

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    req_nxt   = req;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.core_req || dbg_pick) begin
          owner_nxt = dbg_pick ? OWN_DBG : OWN_CORE;
          req_nxt   = dbg_pick ? mk_req(bus.dbg_we, bus.dbg_addr, bus.dbg_wdata)
                               : mk_req(bus.core_we, bus.core_addr, bus.core_wdata);
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        tmr_load  = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        tmr_dec = 1'b1;
        if (tmr_last) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= OWN_CORE;
      req   <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      req   <= req_nxt;
    end
  end

  // The latched request doubles as the registered mem_we/addr/wdata.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en     <= 1'b0;
      core_done  <= 1'b0;
      core_rdata <= '0;
    end else begin
      mem_en    <= (state_nxt == ISSUE);
      core_done <= rsp_cycle && (owner == OWN_CORE);
      if (rsp_cycle && (owner == OWN_CORE) && !req.we) core_rdata <= bus.mem_rdata;
    end
  end

  assign bus.mem_en     = mem_en;
  assign bus.mem_we     = req.we;
  assign bus.mem_addr   = req.addr;
  assign bus.mem_wdata  = req.wdata;
  assign bus.core_done  = core_done;
  assign bus.core_rdata = core_rdata;
  assign bus.pipe_stall = bus.core_req & ~core_done;

`ifdef DMEM_DBG_PORT_EN
  logic [STARVE_W-1:0] starve_cnt;
  logic                starved;
  logic                dbg_done;
  logic [XLEN-1:0]     dbg_rdata;

  assign starved  = (starve_cnt >= STARVE_W'(STARVE_LIMIT));
  assign dbg_pick = bus.dbg_req && (!bus.core_req || starved);

  // Counts core grants taken while debug waits; !starved is the saturation.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      dbg_done   <= 1'b0;
      dbg_rdata  <= '0;
    end else begin
      if (!bus.dbg_req || (state == IDLE && dbg_pick))
        starve_cnt <= '0;
      else if (state == IDLE && bus.core_req && !starved)
        starve_cnt <= starve_cnt + STARVE_W'(1);
      dbg_done <= rsp_cycle && (owner == OWN_DBG);
      if (rsp_cycle && (owner == OWN_DBG) && !req.we) dbg_rdata <= bus.mem_rdata;
    end
  end

  assign bus.dbg_done  = dbg_done;
  assign bus.dbg_rdata = dbg_rdata;
`else
  logic unused_dbg_req;
  assign unused_dbg_req = bus.dbg_req;
  assign dbg_pick       = 1'b0;
  assign bus.dbg_done   = 1'b0;
  assign bus.dbg_rdata  = '0;
`endif

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 2, meaning the number of cycles from the mem_en cycle to the cycle mem_rdata is valid (legal 1..7).
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, meaning the maximum consecutive core grants while dbg_req is pending (legal 1..15).
REQ-003 SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports core_req in 1, core_we in 1, core_addr in XLEN and core_wdata in XLEN, forming the MEM-stage request.
REQ-006 SHALL have ports core_rdata out XLEN, core_done out 1 (one-cycle completion pulse) and pipe_stall out 1 (pipeline hold).
REQ-007 SHALL have ports dbg_req in 1, dbg_we in 1, dbg_addr in XLEN, dbg_wdata in XLEN, dbg_rdata out XLEN and dbg_done out 1, forming the debug/loader port.
REQ-008 SHALL have ports mem_en out 1, mem_we out 1, mem_addr out XLEN, mem_wdata out XLEN and mem_rdata in XLEN, forming the data SRAM port.

Function
REQ-009 SHALL implement FSM states IDLE, ISSUE, WAIT and RESP.
REQ-010 In IDLE with any request, SHALL select an owner, latch its we/addr/wdata and go to ISSUE; with no request, SHALL stay in IDLE.
REQ-011 In IDLE, the core SHALL win unless dbg_req=1 and starve_cnt>=STARVE_LIMIT, in which case debug wins.
REQ-012 starve_cnt SHALL increment on each core grant while dbg_req=1, SHALL clear on a debug grant or whenever dbg_req=0, and SHALL saturate at STARVE_LIMIT.
REQ-013 ISSUE SHALL last 1 cycle: mem_en=1, mem_we/mem_addr/mem_wdata driven from the latched values, wait counter loaded with MEM_LATENCY, next state WAIT.
REQ-014 WAIT SHALL decrement the counter each cycle; in the cycle the counter equals 1, it SHALL sample mem_rdata into the owner's rdata register (reads only) and go to RESP.
REQ-015 RESP SHALL last 1 cycle: owner's done=1 and rdata valid, next state IDLE.
REQ-016 Latency SHALL be fixed: a request seen in IDLE at cycle c SHALL produce done at cycle c+2+MEM_LATENCY.
REQ-017 mem_en SHALL be 1 only in ISSUE; the mem_* outputs SHALL be registered, with mem_addr, mem_wdata and mem_we held from ISSUE until IDLE.
REQ-018 pipe_stall SHALL equal core_req AND NOT core_done, so the pipeline advances on the core_done edge.
REQ-019 Writes SHALL pulse done exactly as reads do; rdata SHALL keep its last read value on writes.
REQ-020 Requesters SHALL hold req and operands until done; a dropped req mid-transaction SHALL still complete and pulse done.
REQ-021 A new request SHALL be accepted only in IDLE, so the minimum spacing between back-to-back transactions is 3+MEM_LATENCY cycles.
REQ-022 core_done and dbg_done SHALL never be 1 in the same cycle.

Reset
REQ-023 With rst=1 at a clock edge, the block SHALL enter IDLE with starve_cnt=0, the counter=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, core_rdata=0, dbg_rdata=0, core_done=0 and dbg_done=0.
REQ-024 Reset mid-transaction SHALL abort it with no done pulse; pipe_stall SHALL follow core_req after reset.

Configuration
REQ-025 Macro DMEM_DBG_PORT_EN defined: the debug port and starvation logic SHALL be present as above.
REQ-026 Macro DMEM_DBG_PORT_EN undefined: the dbg_* ports SHALL remain, dbg_req SHALL be ignored, dbg_done=0, dbg_rdata=0, and no starvation counter SHALL exist; core behaviour SHALL be unchanged.

Structure
REQ-027 XLEN, enum dmem_arb_state_e {IDLE, ISSUE, WAIT, RESP} and enum dmem_owner_e {OWN_CORE, OWN_DBG} SHALL live in the shared defs package.
REQ-028 The wait counter SHALL be a sub-module dmem_lat_timer (load, decrement, last-cycle flag).

Verification
REQ-029 Core read, MEM_LATENCY=2, addr 0x40, mem_rdata=0xDEADBEEF -> mem_en in cycle c+1, core_done and core_rdata=0xDEADBEEF in cycle c+4, pipe_stall=1 from c to c+3.
REQ-030 Core write, addr 0x10, wdata 0x12345678 -> one mem_en cycle with mem_we=1, mem_wdata=0x12345678, core_done at c+4, core_rdata unchanged.
REQ-031 core_req and dbg_req held high continuously, STARVE_LIMIT=4 -> grant order core, core, core, core, dbg, then repeating.
REQ-032 rst asserted in WAIT -> next cycle IDLE, no core_done, mem_en=0, all outputs at reset values.
REQ-033 Build without DMEM_DBG_PORT_EN, dbg_req=1 -> no debug grant, dbg_done stays 0, core reads unaffected.
REQ-034 MEM_LATENCY=1 -> core_done at c+3; MEM_LATENCY=7 -> core_done at c+9.
